// File: rtl/idu_stage.sv
// Registered RV32E/RV32I decode stage between IFU and EXU.
// One-entry output register with valid/ready flow control, flush and a handoff counter.
module idu_stage #(
  parameter bit          RV32E  = 1'b1,
  parameter bit          EN_M   = 1'b0,
  parameter bit          EN_CSR = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic [31:0]      imm,
  output logic [4:0]       alu_op,
  output logic [2:0]       funct3,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src,
  output logic             branch,
  output logic             jal_en,
  output logic             jalr_en,
  output logic             auipc_flag,
  output logic [1:0]       csr_op,
  output logic             csr_imm,
  output logic             ecall,
  output logic             ebreak,
  output logic             mret,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_PASB = 5'd10;
  localparam logic [4:0] ALU_BEQ  = 5'd24;
  localparam logic [4:0] ALU_BNE  = 5'd25;
  localparam logic [4:0] ALU_BLT  = 5'd26;
  localparam logic [4:0] ALU_BGE  = 5'd27;
  localparam logic [4:0] ALU_BLTU = 5'd28;
  localparam logic [4:0] ALU_BGEU = 5'd29;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src;
    logic        branch;
    logic        jal_en;
    logic        jalr_en;
    logic        auipc_flag;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]  f3_alu;
  logic [4:0]  br_alu;
  logic        br_bad;
  bundle_t     dec;
  logic        bad;
  logic        use_rd, use_rs1, use_rs2;

  bundle_t          bundle_q, bundle_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             accept;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Base integer ALU operation selected by funct3 (register and immediate forms).
  always_comb begin
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  end

  // Branch comparison operation selected by funct3; 010/011 are reserved.
  always_comb begin
    br_bad = 1'b0;
    case (f3)
      3'b000:  br_alu = ALU_BEQ;
      3'b001:  br_alu = ALU_BNE;
      3'b100:  br_alu = ALU_BLT;
      3'b101:  br_alu = ALU_BGE;
      3'b110:  br_alu = ALU_BLTU;
      3'b111:  br_alu = ALU_BGEU;
      default: begin
        br_alu = ALU_BEQ;
        br_bad = 1'b1;
      end
    endcase
  end

  // Full decode of the incoming word into the bundle, including legality.
  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    dec.pc     = in_pc;
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    dec.funct3 = f3;
    case (opcode)
      OPC_LUI: begin
        use_rd = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.alu_op = ALU_PASB; dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.auipc_flag = 1'b1; dec.imm = imm_u;
      end
      OPC_JAL: begin
        use_rd = 1'b1; dec.reg_write = 1'b1; dec.jal_en = 1'b1; dec.imm = imm_j;
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.reg_write = 1'b1; dec.jalr_en = 1'b1;
        dec.alu_src = 1'b1; dec.imm = imm_i;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.branch = 1'b1;
        dec.imm = imm_b; dec.alu_op = br_alu; bad = br_bad;
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_i;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.mem_write = 1'b1;
        dec.alu_src = 1'b1; dec.imm = imm_s;
        bad = (f3 >= 3'b011);
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.imm = imm_i; dec.alu_op = f3_alu;
        if (f3 == 3'b001 && f7 != 7'b0) bad = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)     dec.alu_op = ALU_SRA;
          else if (f7 != 7'b0) bad = 1'b1;
        end
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.reg_write = 1'b1;
        if (f7 == 7'b0)                       dec.alu_op = f3_alu;
        else if (f7 == F7_ALT && f3 == 3'b000) dec.alu_op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) dec.alu_op = ALU_SRA;
        else if (EN_M && f7 == F7_MUL)         dec.alu_op = {2'b10, f3};
        else                                   bad = 1'b1;
      end
      OPC_SYSTEM: begin
        if (EN_CSR && f3[1:0] != 2'b00) begin
          use_rd = 1'b1; use_rs1 = !f3[2];
          dec.csr_op = f3[1:0]; dec.csr_imm = f3[2]; dec.reg_write = 1'b1;
          dec.imm = {20'b0, in_inst[31:20]};
        end else if (in_inst == INST_ECALL)           dec.ecall  = 1'b1;
        else if (in_inst == INST_EBREAK)              dec.ebreak = 1'b1;
        else if (EN_CSR && in_inst == INST_MRET)      dec.mret   = 1'b1;
        else                                          bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (RV32E && ((use_rd && in_inst[11]) || (use_rs1 && in_inst[19]) || (use_rs2 && in_inst[24])))
      bad = 1'b1;
    dec.illegal = bad;
    if (bad) begin
      dec.reg_write = 1'b0; dec.mem_read = 1'b0; dec.mem_write = 1'b0;
      dec.branch    = 1'b0; dec.jal_en   = 1'b0; dec.jalr_en   = 1'b0;
      dec.csr_op    = 2'b00; dec.ecall   = 1'b0; dec.ebreak    = 1'b0;
      dec.mret      = 1'b0;
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state for the output register: flush beats accept beats drain.
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    dec_cnt_d   = dec_cnt_q + CNT_W'(out_valid_q && out_ready && !flush);
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      dec_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      dec_cnt_q   <= dec_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign dec_cnt    = dec_cnt_q;
  assign out_pc     = bundle_q.pc;
  assign rs1_addr   = bundle_q.rs1;
  assign rs2_addr   = bundle_q.rs2;
  assign rd_addr    = bundle_q.rd;
  assign imm        = bundle_q.imm;
  assign alu_op     = bundle_q.alu_op;
  assign funct3     = bundle_q.funct3;
  assign mem_read   = bundle_q.mem_read;
  assign mem_write  = bundle_q.mem_write;
  assign mem_to_reg = bundle_q.mem_to_reg;
  assign reg_write  = bundle_q.reg_write;
  assign alu_src    = bundle_q.alu_src;
  assign branch     = bundle_q.branch;
  assign jal_en     = bundle_q.jal_en;
  assign jalr_en    = bundle_q.jalr_en;
  assign auipc_flag = bundle_q.auipc_flag;
  assign csr_op     = bundle_q.csr_op;
  assign csr_imm    = bundle_q.csr_imm;
  assign ecall      = bundle_q.ecall;
  assign ebreak     = bundle_q.ebreak;
  assign mret       = bundle_q.mret;
  assign illegal    = bundle_q.illegal;

endmodule
